// File: rtl/gshare_predictor.sv
// -----------------------------------------------------------------------------
// gshare_predictor
//   Branch direction predictor for the 5-stage pipeline. A table of 2-bit
//   saturating counters (PHT) is indexed by PC[IDX_W+1:2] XOR a speculative
//   global history register (GHR). Fetch gets a combinational prediction; EX
//   trains the counters and repairs the GHR on a mispredict. After reset a
//   sweep writes CNT_INIT into every PHT entry before the predictor goes live.
//
// Handshake / timing contract (applies to every input group below):
//   - pred_req is a one-sided valid: the predictor is always able to answer,
//     so there is no ready back-pressure. The lookup result is combinational
//     in the same cycle; the GHR shift happens on the following edge.
//   - upd_valid is a one-sided valid qualifying upd_pc/upd_ghr/upd_taken/
//     upd_mispred. The update is accepted on the edge where upd_valid=1 and
//     the predictor is in RUN; during the sweep it is dropped.
//   - ready reports that the sweep finished; requests while ready=0 are
//     ignored rather than stalled.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   ready           high once the PHT sweep is complete
//   pc_if           fetch PC for the lookup
//   pred_req        lookup valid; advances the speculative GHR
//   pred_taken      prediction for pc_if (combinational)
//   pred_ghr        GHR snapshot used by this lookup
//   upd_*           resolved-branch training / repair inputs from EX
//   stat_branches   saturating count of accepted updates
//   stat_mispred    saturating count of accepted mispredicts
//   state_dbg       current FSM state (0 = INIT sweep, 1 = RUN)
// -----------------------------------------------------------------------------
module gshare_predictor #(
   parameter int         HIST_W   = 8,
   parameter int         IDX_W    = 9,
   parameter logic [1:0] CNT_INIT = 2'b01,
   parameter int         STAT_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   output logic              ready,
   input  logic [31:0]       pc_if,
   input  logic              pred_req,
   output logic              pred_taken,
   output logic [HIST_W-1:0] pred_ghr,
   input  logic              upd_valid,
   input  logic [31:0]       upd_pc,
   input  logic [HIST_W-1:0] upd_ghr,
   input  logic              upd_taken,
   input  logic              upd_mispred,
   output logic [STAT_W-1:0] stat_branches,
   output logic [STAT_W-1:0] stat_mispred,
   output logic              state_dbg
);

   localparam int PHT_N = 1 << IDX_W;

   typedef enum logic {
      S_INIT = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t            state;
   logic              ready_q;
   logic [IDX_W-1:0]  sweep_ptr;
   logic [HIST_W-1:0] ghr;
   logic [STAT_W-1:0] stat_br_q;
   logic [STAT_W-1:0] stat_mp_q;

   logic [1:0]        pht [PHT_N];

   logic [IDX_W-1:0]  lookup_idx;
   logic [IDX_W-1:0]  upd_idx;
   logic [1:0]        lookup_cnt;
   logic [1:0]        upd_cnt;
   logic [1:0]        upd_cnt_next;
   logic              upd_accept;
   logic              unused_bits;

   // History is zero-extended on the left, so with HIST_W < IDX_W the upper
   // index bits come straight from the PC.
   function automatic logic [IDX_W-1:0] pht_index(input logic [31:0] pc,
                                                  input logic [HIST_W-1:0] h);
      return pc[IDX_W+1:2] ^ IDX_W'(h);
   endfunction

   // Shift-in written as shift-then-overwrite so HIST_W=1 needs no special case.
   function automatic logic [HIST_W-1:0] ghr_shift(input logic [HIST_W-1:0] h,
                                                   input logic b);
      logic [HIST_W-1:0] r;
      r    = h << 1;
      r[0] = b;
      return r;
   endfunction

   assign lookup_idx = pht_index(pc_if, ghr);
   assign upd_idx    = pht_index(upd_pc, upd_ghr);

   // Asynchronous read: a same-cycle update to the same index is seen only
   // after the edge, giving read-before-write behaviour.
   assign lookup_cnt = pht[lookup_idx];
   assign upd_cnt    = pht[upd_idx];

   always_comb begin
      upd_cnt_next = upd_cnt;
      if (upd_taken) begin
         if (upd_cnt != 2'b11) upd_cnt_next = upd_cnt + 2'b01;
      end else begin
         if (upd_cnt != 2'b00) upd_cnt_next = upd_cnt - 2'b01;
      end
   end

   assign upd_accept = (state == S_RUN) && upd_valid;

   assign ready         = ready_q;
   assign pred_taken    = (state == S_RUN) && lookup_cnt[1];
   assign pred_ghr      = (state == S_RUN) ? ghr : '0;
   assign stat_branches = stat_br_q;
   assign stat_mispred  = stat_mp_q;
   assign state_dbg     = state;

   // Control state, history and statistics.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_INIT;
         ready_q   <= 1'b0;
         sweep_ptr <= '0;
         ghr       <= '0;
         stat_br_q <= '0;
         stat_mp_q <= '0;
      end else begin
         case (state)
            S_INIT: begin
               sweep_ptr <= sweep_ptr + IDX_W'(1);
               if (sweep_ptr == IDX_W'(PHT_N - 1)) begin
                  state   <= S_RUN;
                  ready_q <= 1'b1;
               end
            end
            S_RUN: begin
               // Repair from EX wins over the speculative shift from IF.
               if (upd_valid && upd_mispred)
                  ghr <= ghr_shift(upd_ghr, upd_taken);
               else if (pred_req)
                  ghr <= ghr_shift(ghr, pred_taken);

               if (upd_valid) begin
                  if (stat_br_q != '1) stat_br_q <= stat_br_q + STAT_W'(1);
                  if (upd_mispred && (stat_mp_q != '1))
                     stat_mp_q <= stat_mp_q + STAT_W'(1);
               end
            end
            default: begin
               state   <= S_INIT;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   // PHT storage has a single write port shared by the sweep and training;
   // the two never overlap because training is only accepted in RUN.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == S_INIT)
            pht[sweep_ptr] <= CNT_INIT;
         else if (upd_accept)
            pht[upd_idx] <= upd_cnt_next;
      end
   end

   assign unused_bits = ^{pc_if[31:IDX_W+2], pc_if[1:0],
                          upd_pc[31:IDX_W+2], upd_pc[1:0], lookup_cnt[0]};

endmodule

// File: tb/tb_gshare_predictor.sv
module tb_gshare_predictor;

   localparam int         HIST_W   = 8;
   localparam int         IDX_W    = 9;
   localparam logic [1:0] CNT_INIT = 2'b01;
   localparam int         STAT_W   = 8;
   localparam int         PHT_N    = 1 << IDX_W;
   localparam int         HMAX     = (1 << HIST_W) - 1;
   localparam int         SMAX     = (1 << STAT_W) - 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic              ready;
   logic [31:0]       pc_if;
   logic              pred_req;
   logic              pred_taken;
   logic [HIST_W-1:0] pred_ghr;
   logic              upd_valid;
   logic [31:0]       upd_pc;
   logic [HIST_W-1:0] upd_ghr;
   logic              upd_taken;
   logic              upd_mispred;
   logic [STAT_W-1:0] stat_branches;
   logic [STAT_W-1:0] stat_mispred;
   logic              state_dbg;

   gshare_predictor #(
      .HIST_W(HIST_W), .IDX_W(IDX_W), .CNT_INIT(CNT_INIT), .STAT_W(STAT_W)
   ) dut (
      .clk(clk), .rst(rst), .ready(ready),
      .pc_if(pc_if), .pred_req(pred_req), .pred_taken(pred_taken), .pred_ghr(pred_ghr),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
      .upd_taken(upd_taken), .upd_mispred(upd_mispred),
      .stat_branches(stat_branches), .stat_mispred(stat_mispred),
      .state_dbg(state_dbg)
   );

   int n_cmp = 0;
   int n_err = 0;
   logic [0:0] exp_q[$];

   // ---------------- reference model ----------------
   // Counters are plain integers 0..3; the sweep is modelled as a countdown
   // after which every entry simply holds the initial value.
   int m_pht [PHT_N];
   int m_left;
   int m_ghr;
   int m_br;
   int m_mis;

   function automatic int m_idx(input logic [31:0] pc, input int h);
      return ((int'(pc >> 2)) ^ h) % PHT_N;
   endfunction

   function automatic bit m_ready();
      return m_left == 0;
   endfunction

   function automatic bit m_pred(input logic [31:0] pc);
      return m_ready() && (m_pht[m_idx(pc, m_ghr)] >= 2);
   endfunction

   task automatic model_edge();
      int ui;
      int g;
      if (rst) begin
         m_left = PHT_N;
         m_ghr  = 0;
         m_br   = 0;
         m_mis  = 0;
         return;
      end
      if (m_left > 0) begin
         m_left--;
         if (m_left == 0)
            for (int i = 0; i < PHT_N; i++) m_pht[i] = int'(CNT_INIT);
         return;
      end
      g = m_ghr;
      if (pred_req) g = ((m_ghr * 2) + int'(m_pred(pc_if))) & HMAX;
      if (upd_valid && upd_mispred) g = ((int'(upd_ghr) * 2) + int'(upd_taken)) & HMAX;
      if (upd_valid) begin
         ui = m_idx(upd_pc, int'(upd_ghr));
         if (upd_taken) m_pht[ui] = (m_pht[ui] < 3) ? m_pht[ui] + 1 : 3;
         else           m_pht[ui] = (m_pht[ui] > 0) ? m_pht[ui] - 1 : 0;
         if (m_br < SMAX) m_br++;
         if (upd_mispred && m_mis < SMAX) m_mis++;
      end
      m_ghr = g;
   endtask

   // ---------------- driver / checker tasks ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      check("ready", 32'(ready), 32'(m_ready()));
      check("state_dbg", 32'(state_dbg), 32'(m_ready()));
      check("pred_taken", 32'(pred_taken), 32'(m_pred(pc_if)));
      check("pred_ghr", 32'(pred_ghr), m_ready() ? 32'(m_ghr) : 32'd0);
      check("stat_branches", 32'(stat_branches), 32'(m_br));
      check("stat_mispred", 32'(stat_mispred), 32'(m_mis));
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      pred_req    = 1'b0;
      upd_valid   = 1'b0;
      upd_mispred = 1'b0;
      upd_taken   = 1'b0;
      upd_pc      = '0;
      upd_ghr     = '0;
   endtask

   task automatic train(input logic [31:0] pc, input logic [HIST_W-1:0] h,
                        input logic taken, input logic mis);
      upd_valid   = 1'b1;
      upd_pc      = pc;
      upd_ghr     = h;
      upd_taken   = taken;
      upd_mispred = mis;
      tick();
      idle();
   endtask

   task automatic drive_random();
      pc_if       = ($urandom & 32'hFFFF_F803) | (32'($urandom_range(0, 31)) << 2);
      pred_req    = 1'($urandom_range(0, 1));
      upd_valid   = 1'($urandom_range(0, 1));
      upd_pc      = ($urandom & 32'hFFFF_F803) | (32'($urandom_range(0, 31)) << 2);
      upd_ghr     = HIST_W'($urandom_range(0, 7));
      upd_taken   = 1'($urandom_range(0, 1));
      upd_mispred = ($urandom_range(0, 3) == 0);
   endtask

   // Applies a reset and counts cycles until ready, checking every cycle.
   task automatic reset_and_sweep(input string tag);
      int cyc;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check({tag, "_stat_br_zero"}, 32'(stat_branches), 32'd0);
      check({tag, "_stat_mis_zero"}, 32'(stat_mispred), 32'd0);
      cyc = 0;
      while (!ready && cyc < 2000) begin
         drive_random();
         #1;
         check({tag, "_sweep_pred0"}, 32'(pred_taken), 32'd0);
         check_model();
         tick();
         cyc++;
      end
      check({tag, "_sweep_cycles"}, 32'(cyc), 32'(PHT_N));
      idle();
   endtask

   typedef struct {
      logic taken;
      logic exp_pred;
   } train_vec_t;

   train_vec_t tv [8];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Counter walk at pc 0x100, ghr 0: 01 -> 10 -> 11 -> 11 -> 10 -> 01 -> 00 -> 00 -> 01
      tv[0] = '{1'b1, 1'b1};
      tv[1] = '{1'b1, 1'b1};
      tv[2] = '{1'b1, 1'b1};
      tv[3] = '{1'b0, 1'b1};
      tv[4] = '{1'b0, 1'b0};
      tv[5] = '{1'b0, 1'b0};
      tv[6] = '{1'b0, 1'b0};
      tv[7] = '{1'b1, 1'b0};

      rst   = 1'b1;
      pc_if = '0;
      idle();
      m_left = PHT_N;

      // Reset sweep with junk requests that must be ignored.
      reset_and_sweep("sweep1");
      check("ready_after_sweep", 32'(ready), 32'd1);
      check("ghr_after_sweep", 32'(pred_ghr), 32'd0);

      // Counter training and saturation.
      foreach (tv[i]) begin
         train(32'h100, '0, tv[i].taken, 1'b0);
         pc_if = 32'h100;
         #1;
         check($sformatf("train_row%0d", i), 32'(pred_taken), 32'(tv[i].exp_pred));
      end

      // GHR shift with predictions 1,0,1.
      train(32'h200, 8'h00, 1'b1, 1'b0);
      train(32'h200, 8'h00, 1'b1, 1'b0);
      train(32'h400, 8'h02, 1'b1, 1'b0);
      train(32'h400, 8'h02, 1'b1, 1'b0);
      exp_q.push_back(1'b1);
      exp_q.push_back(1'b0);
      exp_q.push_back(1'b1);
      foreach (exp_q[i]) begin
         pc_if    = (i == 0) ? 32'h200 : (i == 1) ? 32'h300 : 32'h400;
         pred_req = 1'b1;
         #1;
         check($sformatf("shift_pred%0d", i), 32'(pred_taken), 32'(exp_q[i]));
         tick();
      end
      exp_q.delete();
      idle();
      #1;
      check("shift_ghr", 32'(pred_ghr), 32'h05);

      // Repair overrides a same-cycle speculative shift.
      pc_if       = 32'h200;
      pred_req    = 1'b1;
      upd_valid   = 1'b1;
      upd_pc      = 32'h800;
      upd_ghr     = 8'h3C;
      upd_taken   = 1'b1;
      upd_mispred = 1'b1;
      tick();
      idle();
      #1;
      check("repair_ghr", 32'(pred_ghr), 32'h79);

      // Read-before-write collision on index 0x139 (counter 01).
      pc_if     = 32'h500;
      upd_valid = 1'b1;
      upd_pc    = 32'h500;
      upd_ghr   = 8'h79;
      upd_taken = 1'b1;
      #1;
      check("collide_same_cycle", 32'(pred_taken), 32'd0);
      tick();
      idle();
      #1;
      check("collide_next_cycle", 32'(pred_taken), 32'd1);
      check_model();

      // Randomised traffic against the reference model.
      for (int n = 0; n < 200; n++) begin
         drive_random();
         #1;
         check_model();
         tick();
      end
      idle();

      // Drive both statistics counters to saturation, then one more update.
      for (int n = 0; n < 600 && m_mis < SMAX; n++) begin
         drive_random();
         upd_valid   = 1'b1;
         upd_mispred = 1'b1;
         tick();
      end
      check("stat_br_full", 32'(stat_branches), 32'(SMAX));
      check("stat_mis_full", 32'(stat_mispred), 32'(SMAX));
      train(32'h600, 8'h11, 1'b0, 1'b1);
      #1;
      check("stat_br_sat", 32'(stat_branches), 32'hFF);
      check("stat_mis_sat", 32'(stat_mispred), 32'hFF);
      check_model();

      // Reset in the middle of a sweep restarts it from scratch.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int n = 0; n < 100; n++) begin
         drive_random();
         tick();
      end
      check("midsweep_not_ready", 32'(ready), 32'd0);
      reset_and_sweep("sweep2");
      pc_if = 32'h100;
      #1;
      check("sweep2_pht_cleared", 32'(pred_taken), 32'd0);
      check_model();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
